// File: rtl/stack_mem_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : stack_mem_sequencer_if
// Purpose  : MEM-stage stack request, load/store and data-memory port bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface stack_mem_sequencer_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
);
   logic                  req_valid;
   logic [2:0]            req_op;
   logic [2*DATA_W-1:0]   pc_in;
   logic [3:0]            flags_in;
   logic [DATA_W-1:0]     push_data;
   logic                  ls_rd;
   logic                  ls_wr;
   logic [ADDR_W-1:0]     ls_addr;
   logic [DATA_W-1:0]     ls_wdata;
   logic [DATA_W-1:0]     mem_rdata;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic                  mem_we;
   logic                  mem_re;
   logic                  stall;
   logic [2*DATA_W-1:0]   pc_out;
   logic                  pc_out_valid;
   logic [3:0]            flags_out;
   logic                  flags_out_valid;
   logic [DATA_W-1:0]     pop_data;
   logic                  pop_valid;
   logic [ADDR_W-1:0]     sp;

   modport master (
      output req_valid, req_op, pc_in, flags_in, push_data,
             ls_rd, ls_wr, ls_addr, ls_wdata, mem_rdata,
      input  mem_addr, mem_wdata, mem_we, mem_re, stall,
             pc_out, pc_out_valid, flags_out, flags_out_valid,
             pop_data, pop_valid, sp
   );

   modport slave (
      input  req_valid, req_op, pc_in, flags_in, push_data,
             ls_rd, ls_wr, ls_addr, ls_wdata, mem_rdata,
      output mem_addr, mem_wdata, mem_we, mem_re, stall,
             pc_out, pc_out_valid, flags_out, flags_out_valid,
             pop_data, pop_valid, sp
   );
endinterface
`default_nettype wire

// File: rtl/stack_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stack_mem_sequencer
// Purpose  : Sequences multi-word stack transactions onto the single-port data
//            memory, owns SP, stalls the pipeline, else passes load/store through.
// Revision : 1.0 - initial release
// ============================================================================
module stack_mem_sequencer #(
   parameter int                ADDR_W   = 12,
   parameter int                DATA_W   = 16,
   parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
   input  logic                 clk,
   input  logic                 rst,
   stack_mem_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PUSH = 3'd1,
      S_POP  = 3'd2,
      S_CAPT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [2:0] c_OP_PUSH = 3'd1;
   localparam logic [2:0] c_OP_POP  = 3'd2;
   localparam logic [2:0] c_OP_CALL = 3'd3;
   localparam logic [2:0] c_OP_RET  = 3'd4;
   localparam logic [2:0] c_OP_INT  = 3'd5;
   localparam logic [2:0] c_OP_RTI  = 3'd6;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [2:0]            r_op;
   logic [2*DATA_W-1:0]   r_pc;
   logic [3:0]            r_flags;
   logic [DATA_W-1:0]     r_push_data;
   logic [1:0]            r_idx;
   logic [1:0]            r_last;
   logic [ADDR_W-1:0]     r_sp;
   logic [2*DATA_W-1:0]   r_pc_out;
   logic [3:0]            r_flags_out;
   logic [DATA_W-1:0]     r_pop_data;

   logic                  w_accept;
   logic [1:0]            w_last_nxt;
   logic [DATA_W-1:0]     w_push_word;
   logic                  w_cap_en;
   logic [1:0]            w_cap_idx;

   // Odd opcodes push, even opcodes pop; 0 and 7 are no-ops.
   assign w_accept = !rst && (r_state == S_IDLE) && bus.req_valid &&
                     (bus.req_op >= c_OP_PUSH) && (bus.req_op <= c_OP_RTI);

   always_comb begin
      w_last_nxt = 2'd0;
      case (bus.req_op)
         c_OP_CALL, c_OP_RET: w_last_nxt = 2'd1;
         c_OP_INT,  c_OP_RTI: w_last_nxt = 2'd2;
         default:             w_last_nxt = 2'd0;
      endcase
   end

   always_comb begin
      w_push_word = r_push_data;
      case (r_op)
         c_OP_CALL: w_push_word = (r_idx == 2'd0) ? r_pc[2*DATA_W-1:DATA_W]
                                                  : r_pc[DATA_W-1:0];
         c_OP_INT: begin
            if (r_idx == 2'd0)
               w_push_word = {{(DATA_W-4){1'b0}}, r_flags};
            else if (r_idx == 2'd1)
               w_push_word = r_pc[2*DATA_W-1:DATA_W];
            else
               w_push_word = r_pc[DATA_W-1:0];
         end
         default: w_push_word = r_push_data;
      endcase
   end

   // Read data lags the read by one cycle, so each POP edge after the first
   // and the CAPT edge retire the previous word.
   assign w_cap_en  = ((r_state == S_POP) && (r_idx != 2'd0)) || (r_state == S_CAPT);
   assign w_cap_idx = (r_state == S_CAPT) ? r_last : (r_idx - 2'd1);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = bus.req_op[0] ? S_PUSH : S_POP;
         S_PUSH: if (r_idx == r_last) w_state_nxt = S_DONE;
         S_POP:  if (r_idx == r_last) w_state_nxt = S_CAPT;
         S_CAPT: w_state_nxt = S_DONE;
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.mem_we    = 1'b0;
      bus.mem_re    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.stall     = 1'b0;
      if (!rst) begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  bus.stall = 1'b1;
               end else begin
                  bus.mem_we    = bus.ls_wr;
                  bus.mem_re    = bus.ls_rd;
                  bus.mem_addr  = bus.ls_addr;
                  bus.mem_wdata = bus.ls_wdata;
               end
            end
            S_PUSH: begin
               bus.stall     = 1'b1;
               bus.mem_we    = 1'b1;
               bus.mem_addr  = r_sp;
               bus.mem_wdata = w_push_word;
            end
            S_POP: begin
               bus.stall    = 1'b1;
               bus.mem_re   = 1'b1;
               bus.mem_addr = r_sp + ADDR_W'(1);
            end
            S_CAPT:  bus.stall = 1'b1;
            default: bus.stall = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_op        <= '0;
         r_pc        <= '0;
         r_flags     <= '0;
         r_push_data <= '0;
         r_idx       <= '0;
         r_last      <= '0;
         r_sp        <= SP_RESET;
         r_pc_out    <= '0;
         r_flags_out <= '0;
         r_pop_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_op        <= bus.req_op;
            r_pc        <= bus.pc_in;
            r_flags     <= bus.flags_in;
            r_push_data <= bus.push_data;
            r_idx       <= 2'd0;
            r_last      <= w_last_nxt;
         end
         if (r_state == S_PUSH) begin
            r_sp  <= r_sp - ADDR_W'(1);
            r_idx <= r_idx + 2'd1;
         end
         if (r_state == S_POP) begin
            r_sp  <= r_sp + ADDR_W'(1);
            r_idx <= r_idx + 2'd1;
         end
         if (w_cap_en) begin
            if (r_op == c_OP_POP)
               r_pop_data <= bus.mem_rdata;
            else if (w_cap_idx == 2'd0)
               r_pc_out[DATA_W-1:0] <= bus.mem_rdata;
            else if (w_cap_idx == 2'd1)
               r_pc_out[2*DATA_W-1:DATA_W] <= bus.mem_rdata;
            else
               r_flags_out <= bus.mem_rdata[3:0];
         end
      end
   end

   assign bus.sp              = r_sp;
   assign bus.pc_out          = r_pc_out;
   assign bus.flags_out       = r_flags_out;
   assign bus.pop_data        = r_pop_data;
   assign bus.pc_out_valid    = (r_state == S_DONE) && ((r_op == c_OP_RET) || (r_op == c_OP_RTI));
   assign bus.flags_out_valid = (r_state == S_DONE) && (r_op == c_OP_RTI);
   assign bus.pop_valid       = (r_state == S_DONE) && (r_op == c_OP_POP);
endmodule
`default_nettype wire

// File: tb/tb_stack_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_mem_sequencer
// Purpose  : Directed self-checking bench with a word-level stack model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_mem_sequencer;
   localparam int AW = 12;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   stack_mem_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

   stack_mem_sequencer #(.ADDR_W(AW), .DATA_W(DW), .SP_RESET({AW{1'b1}})) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Data memory attached to the DUT port.
   logic [DW-1:0] env_mem [0:4095];
   always @(posedge clk) begin
      if (bus.mem_we) env_mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= env_mem[bus.mem_addr];
   end

   // Model state: stack contents and pointer.
   logic [DW-1:0] m_mem [0:4095];
   logic [AW-1:0] m_sp;

   int n_pass  = 0;
   int n_total = 0;

   bit            exp_en;
   bit            e_stall, e_we, e_re, e_pcv, e_fv, e_popv;
   logic [AW-1:0] e_addr, e_sp;
   logic [DW-1:0] e_wdata, e_pop;
   logic [31:0]   e_pc;
   logic [3:0]    e_flags;

   int            d_stalls, d_pulses;
   logic [31:0]   s_pc, d_pc;
   logic [3:0]    s_flags, d_flags;
   logic [DW-1:0] s_pop, d_pop;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic exp_cycle(input bit st, input bit we, input bit re,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                            input logic [AW-1:0] spv);
      e_stall = st; e_we = we; e_re = re; e_addr = addr; e_wdata = wd; e_sp = spv;
      e_pcv = 1'b0; e_fv = 1'b0; e_popv = 1'b0;
   endtask

   always @(negedge clk) begin
      if (exp_en) begin
         chk("stall", 32'(bus.stall), 32'(e_stall));
         chk("mem_we", 32'(bus.mem_we), 32'(e_we));
         chk("mem_re", 32'(bus.mem_re), 32'(e_re));
         if (e_we || e_re) chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
         if (e_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
         chk("sp", 32'(bus.sp), 32'(e_sp));
         chk("pc_out_valid", 32'(bus.pc_out_valid), 32'(e_pcv));
         chk("flags_out_valid", 32'(bus.flags_out_valid), 32'(e_fv));
         chk("pop_valid", 32'(bus.pop_valid), 32'(e_popv));
         if (e_pcv) chk("pc_out", bus.pc_out, e_pc);
         if (e_fv) chk("flags_out", 32'(bus.flags_out), 32'(e_flags));
         if (e_popv) chk("pop_data", 32'(bus.pop_data), 32'(e_pop));
      end
   end

   task automatic step();
      @(negedge clk);
      if (bus.stall) d_stalls++;
      if (bus.pc_out_valid || bus.flags_out_valid || bus.pop_valid) d_pulses++;
      s_pc = bus.pc_out; s_flags = bus.flags_out; s_pop = bus.pop_data;
      @(posedge clk);
      #1;
   endtask

   // One full transaction: acceptance, word cycles, DONE, then one idle cycle.
   task automatic run_op(input logic [2:0] op, input logic [31:0] pc, input logic [3:0] fl,
                         input logic [DW-1:0] pd, input bit hold);
      logic [AW-1:0] s, fs;
      logic [DW-1:0] w [3];
      int            n;
      bit            is_push;
      s = m_sp;
      is_push = (op == 3'd1) || (op == 3'd3) || (op == 3'd5);
      w[0] = '0; w[1] = '0; w[2] = '0;
      case (op)
         3'd1: begin n = 1; w[0] = pd; end
         3'd3: begin n = 2; w[0] = pc[31:16]; w[1] = pc[15:0]; end
         3'd5: begin n = 3; w[0] = {12'b0, fl}; w[1] = pc[31:16]; w[2] = pc[15:0]; end
         3'd2: n = 1;
         3'd4: n = 2;
         default: n = 3;
      endcase
      d_stalls = 0; d_pulses = 0;
      bus.req_valid = 1'b1; bus.req_op = op;
      bus.pc_in = pc; bus.flags_in = fl; bus.push_data = pd;
      exp_cycle(1, 0, 0, '0, '0, s);
      step();
      if (!hold) bus.req_valid = 1'b0;
      bus.pc_in = ~pc; bus.flags_in = ~fl; bus.push_data = ~pd;
      if (is_push) begin
         for (int c = 0; c < n; c++) begin
            exp_cycle(1, 1, 0, AW'(s - c), w[c], AW'(s - c));
            m_mem[AW'(s - c)] = w[c];
            step();
         end
         fs = AW'(s - n);
      end else begin
         for (int c = 1; c <= n; c++) begin
            exp_cycle(1, 0, 1, AW'(s + c), '0, AW'(s + c - 1));
            step();
         end
         exp_cycle(1, 0, 0, '0, '0, AW'(s + n));
         step();
         fs = AW'(s + n);
      end
      exp_cycle(0, 0, 0, '0, '0, fs);
      e_pcv   = (op == 3'd4) || (op == 3'd6);
      e_fv    = (op == 3'd6);
      e_popv  = (op == 3'd2);
      e_pc    = {m_mem[AW'(s + 2)], m_mem[AW'(s + 1)]};
      e_flags = m_mem[AW'(s + 3)][3:0];
      e_pop   = m_mem[AW'(s + 1)];
      step();
      d_pc = s_pc; d_flags = s_flags; d_pop = s_pop;
      bus.req_valid = 1'b0;
      bus.ls_wr = 1'b0; bus.ls_rd = 1'b0;
      m_sp = fs;
      exp_cycle(0, 0, 0, '0, '0, m_sp);
      step();
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_sp"}, 32'(bus.sp), 32'hFFF);
      chk({tag, "_stall"}, 32'(bus.stall), 32'd0);
      chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
      chk({tag, "_mem_re"}, 32'(bus.mem_re), 32'd0);
      chk({tag, "_pc_out"}, bus.pc_out, 32'd0);
      chk({tag, "_flags_out"}, 32'(bus.flags_out), 32'd0);
      chk({tag, "_pop_data"}, 32'(bus.pop_data), 32'd0);
      chk({tag, "_valids"}, 32'({bus.pc_out_valid, bus.flags_out_valid, bus.pop_valid}), 32'd0);
   endtask

   initial begin
      logic [AW-1:0] s;
      exp_en = 1'b0;
      bus.req_valid = 1'b0; bus.req_op = '0; bus.pc_in = '0; bus.flags_in = '0;
      bus.push_data = '0; bus.ls_rd = 1'b0; bus.ls_wr = 1'b0; bus.ls_addr = '0;
      bus.ls_wdata = '0;
      for (int i = 0; i < 4096; i++) m_mem[i] = '0;
      m_sp = 12'hFFF;
      exp_cycle(0, 0, 0, '0, '0, m_sp);
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("por");
      rst = 1'b0;
      exp_en = 1'b1;
      step();

      run_op(3'd3, 32'h12345678, 4'h0, 16'h0, 1'b0);
      chk("call_stalls", 32'(d_stalls), 32'd3);
      chk("call_word_hi", 32'(env_mem[12'hFFF]), 32'h1234);
      chk("call_word_lo", 32'(env_mem[12'hFFE]), 32'h5678);
      chk("call_sp", 32'(bus.sp), 32'hFFD);
      run_op(3'd4, 32'h0, 4'h0, 16'h0, 1'b0);
      chk("ret_pc", d_pc, 32'h12345678);
      chk("ret_stalls", 32'(d_stalls), 32'd4);
      chk("ret_pulses", 32'(d_pulses), 32'd1);
      chk("ret_sp", 32'(bus.sp), 32'hFFF);

      run_op(3'd5, 32'h00AB00CD, 4'b1011, 16'h0, 1'b0);
      chk("int_stalls", 32'(d_stalls), 32'd4);
      chk("int_flag_word", 32'(env_mem[12'hFFF]), 32'h000B);
      run_op(3'd6, 32'h0, 4'h0, 16'h0, 1'b0);
      chk("rti_pc", d_pc, 32'h00AB00CD);
      chk("rti_flags", 32'(d_flags), 32'hB);
      chk("rti_stalls", 32'(d_stalls), 32'd5);
      chk("rti_sp", 32'(bus.sp), 32'hFFF);

      run_op(3'd1, 32'h0, 4'h0, 16'hBEEF, 1'b1);
      chk("push_stalls", 32'(d_stalls), 32'd2);
      run_op(3'd2, 32'h0, 4'h0, 16'h0, 1'b1);
      chk("pop_data_lit", 32'(d_pop), 32'hBEEF);
      chk("pop_pulses", 32'(d_pulses), 32'd1);
      chk("pop_stalls", 32'(d_stalls), 32'd3);
      chk("pop_sp", 32'(bus.sp), 32'hFFF);

      bus.ls_wr = 1'b1; bus.ls_addr = 12'h010; bus.ls_wdata = 16'h55AA;
      exp_cycle(0, 1, 0, 12'h010, 16'h55AA, m_sp);
      m_mem[12'h010] = 16'h55AA;
      step();
      bus.ls_wr = 1'b0; bus.ls_rd = 1'b1;
      exp_cycle(0, 0, 1, 12'h010, '0, m_sp);
      step();
      bus.ls_rd = 1'b0;
      chk("ls_write", 32'(env_mem[12'h010]), 32'h55AA);

      bus.ls_wr = 1'b1; bus.ls_addr = 12'h010; bus.ls_wdata = 16'h1111;
      run_op(3'd3, 32'hCAFE0001, 4'h0, 16'h0, 1'b0);
      chk("prio_ls_absent", 32'(env_mem[12'h010]), 32'h55AA);
      chk("prio_stack_word", 32'(env_mem[12'hFFF]), 32'hCAFE);
      run_op(3'd4, 32'h0, 4'h0, 16'h0, 1'b0);
      chk("prio_ret_pc", d_pc, 32'hCAFE0001);

      s = m_sp;
      bus.req_valid = 1'b1; bus.req_op = 3'd5; bus.pc_in = 32'h11112222; bus.flags_in = 4'hF;
      exp_cycle(1, 0, 0, '0, '0, s);
      step();
      exp_cycle(1, 1, 0, s, 16'h000F, s);
      m_mem[s] = 16'h000F;
      step();
      exp_en = 1'b0;
      rst = 1'b1;
      #1;
      chk_reset_state("mid_int_rst");
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      rst = 1'b0;
      m_sp = 12'hFFF;
      exp_cycle(0, 0, 0, '0, '0, m_sp);
      exp_en = 1'b1;
      step();

      for (int i = 0; i < 4095; i++) run_op(3'd1, 32'h0, 4'h0, 16'(i), 1'b0);
      chk("wrap_sp_zero", 32'(bus.sp), 32'h000);
      run_op(3'd1, 32'h0, 4'h0, 16'h0001, 1'b0);
      chk("wrap_word0", 32'(env_mem[12'h000]), 32'h0001);
      chk("wrap_sp_max", 32'(bus.sp), 32'hFFF);
      run_op(3'd2, 32'h0, 4'h0, 16'h0, 1'b0);
      chk("wrap_pop", 32'(d_pop), 32'h0001);

      exp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/stack_mem_sequencer.md
# stack_mem_sequencer

Multi-cycle stack transaction sequencer and data-memory port arbiter in the MEM stage. It owns the stack pointer. It sequences CALL/INT/RET/RTI and PUSH/POP into single-word accesses on the single-port data memory, and stalls the pipeline for the duration. When no stack transaction is active, the MEM-stage load/store port passes through to the memory.

## Interface
- ADDR_W, 12, memory word-address width; SP width.
- DATA_W, 16, memory word width; PC is 2*DATA_W, flags occupy low 4 bits of a word.
- SP_RESET, {ADDR_W{1'b1}}, stack pointer reset value (top of memory).

- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  stack request from MEM stage.
- req_op  in  3  0 NONE, 1 PUSH, 2 POP, 3 CALL, 4 RET, 5 INT, 6 RTI, 7 reserved (treated as NONE).
- pc_in  in  2*DATA_W  return PC for CALL/INT.
- flags_in  in  4  CCR for INT.
- push_data  in  DATA_W  word for PUSH.
- ls_rd, ls_wr  in  1 each  normal load/store.
- ls_addr  in  ADDR_W; ls_wdata  in  DATA_W.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_re.
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_we, mem_re  out  1.
- stall  out  1  freeze IF..MEM.
- pc_out  out  2*DATA_W; pc_out_valid  out  1  popped PC (RET/RTI).
- flags_out  out  4; flags_out_valid  out  1  popped CCR (RTI).
- pop_data  out  DATA_W; pop_valid  out  1  popped word (POP).
- sp  out  ADDR_W  current stack pointer.

## Operation
- States: IDLE, PUSH, POP, CAPT, DONE. SP points to next free word. Pushes write at SP, then SP-1. Pops read at SP+1, then SP+1.
- IDLE: if req_valid and op in 1..6, latch op, pc_in, flags_in, push_data, and load the word counter. Go to PUSH for ops 1/3/5 and POP for ops 2/4/6. Otherwise mem_* = ls_* combinationally: mem_re=ls_rd, mem_we=ls_wr, addr/wdata from ls_addr/ls_wdata.
- Push word order, with S being SP at entry:
  - PUSH: S←push_data.
  - CALL: S←PC[31:16], S-1←PC[15:0].
  - INT: S←{12'b0,flags}, S-1←PC[31:16], S-2←PC[15:0].
- Pop word order:
  - POP: S+1→pop_data.
  - RET: S+1→PC[15:0], S+2→PC[31:16].
  - RTI: S+1→PC[15:0], S+2→PC[31:16], S+3→flags (low 4 bits).
- PUSH state: one mem_we per cycle; SP decrements each edge; after the last word, go to DONE.
- POP state: one mem_re per cycle at SP+1; SP increments each edge. mem_rdata from the previous cycle's read is captured on each edge. After the last read, go to CAPT. CAPT captures the final word, then goes to DONE.
- DONE: for one cycle, pc_out_valid, flags_out_valid and pop_valid are asserted as the op dictates. stall=0, req_valid is ignored, and mem_we=mem_re=0. Next state is IDLE. This prevents the still-present request from re-triggering before the pipeline advances.
- stall = (state==IDLE & req_valid & op in 1..6) | state in {PUSH, POP, CAPT}.
- Priority: a stack request beats ls_*. ls_* is ignored whenever the state is not IDLE, or in IDLE with an accepted request.
- SP arithmetic is modulo 2^ADDR_W. It wraps silently: push at 0 gives SP=max, pop at max reads address 0.
- Reset, including mid-transaction: state=IDLE, SP=SP_RESET. pc_out, flags_out and pop_data are 0. All valids, mem_we, mem_re and stall are 0. A partial transaction is abandoned.

## Timing
- Cycle 0 is the acceptance cycle, with stall high combinationally.
- Stall cycles:
  - PUSH: 2 (0,1).
  - CALL: 3.
  - INT: 4.
  - POP: 3 (0, read, capt).
  - RET: 4.
  - RTI: 5.
- DONE follows immediately. Result valids pulse exactly 1 cycle in DONE, and outputs hold their value until the next capture.
- Memory writes occur in cycles 1..N. Reads are issued in cycles 1..N with data captured at the end of cycles 2..N+1.
- sp updates on the edge ending each PUSH/POP cycle. Final SP is visible in DONE.
- Back-to-back requests: minimum one DONE cycle between transactions.

## Test plan
- Reset: assert rst mid-INT at cycle 2 → SP=0xFFF, stall=0, mem_we=0, and all outputs zero immediately.
- CALL pc_in=0x12345678 from SP=0xFFF → writes [0xFFF]=0x1234, [0xFFE]=0x5678; SP=0xFFD; stall high 3 cycles. Follow with RET → pc_out=0x12345678 with one-cycle pc_out_valid in cycle 4, SP=0xFFF.
- INT flags_in=4'b1011, pc_in=0x00AB00CD, then RTI → [0xFFF]=0x000B; pc_out=0x00AB00CD, flags_out=4'b1011; SP back to 0xFFF; RTI stall 5 cycles.
- PUSH 0xBEEF then POP → pop_data=0xBEEF, pop_valid one cycle; SP restored. A held req_valid during DONE does not re-trigger.
- Wrap: SP forced to 0 via pushes, then PUSH 0x0001 → write at 0x000, SP=0xFFF. POP at SP=0xFFF reads address 0x000.
- Passthrough/priority: in IDLE with ls_wr=1, addr=0x010, data=0x55AA → same-cycle mem_we at 0x010. With req_valid=CALL simultaneously → the stack write at SP wins and the ls write is absent.
